// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: state encodings and depth helper.
package fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  function automatic int unsigned fifo_depth(input int unsigned qsize);
    return 32'd1 << qsize;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register; advances by one on i_inc and wraps at 2**W.
module fifo_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control block: pointers, occupancy, status flags, sticky error and
// the RESET/INIT/IDLE/ACTIVE/ERROR sequencing around the storage array.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned MAIN_QUEUE_SIZE = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [MAIN_QUEUE_SIZE:0]   umbral_alto,
  input  logic [MAIN_QUEUE_SIZE:0]   umbral_bajo,
  input  logic                       push,
  input  logic                       pop,
  output logic                       wr_en,
  output logic                       rd_en,
  output logic [MAIN_QUEUE_SIZE-1:0] ptr_write,
  output logic [MAIN_QUEUE_SIZE-1:0] ptr_read,
  output logic                       mem_reset_L,
  output logic [MAIN_QUEUE_SIZE:0]   count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       error,
  output logic [2:0]                 state
);

  localparam int unsigned DEPTH = fifo_depth(MAIN_QUEUE_SIZE);
  localparam int unsigned CW    = MAIN_QUEUE_SIZE + 1;
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] C_ALTO_RST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_BAJO_RST = CW'(1);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_alto;
  logic [CW-1:0] r_bajo;
  logic          r_error;
  logic          r_mem_reset_L;

  logic          w_op_en;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;
  logic          w_overflow;
  logic          w_underflow;
  logic [CW-1:0] w_count_next;

  always_comb begin
    w_full       = (r_count == C_DEPTH);
    w_empty      = (r_count == '0);
    // A configuration request in IDLE wins over push/pop so no entry is
    // written while heading back into INIT.
    w_op_en      = (r_state == ST_ACTIVE) || ((r_state == ST_IDLE) && !init);
    w_wr         = w_op_en & push & (~w_full | pop);
    w_rd         = w_op_en & pop & ~w_empty;
    w_overflow   = w_op_en & push & w_full & ~pop;
    w_underflow  = w_op_en & pop & w_empty;
    w_count_next = r_count + CW'(w_wr) - CW'(w_rd);
  end

  fifo_ptr #(.W(MAIN_QUEUE_SIZE)) u_wr_ptr (
    .clk   (clk),
    .rst   (reset),
    .i_inc (w_wr),
    .o_ptr (ptr_write)
  );

  fifo_ptr #(.W(MAIN_QUEUE_SIZE)) u_rd_ptr (
    .clk   (clk),
    .rst   (reset),
    .i_inc (w_rd),
    .o_ptr (ptr_read)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RESET;
      r_count       <= '0;
      r_error       <= 1'b0;
      r_mem_reset_L <= 1'b0;
      r_alto        <= C_ALTO_RST;
      r_bajo        <= C_BAJO_RST;
    end else begin
      r_count <= w_count_next;
      case (r_state)
        ST_RESET: begin
          r_state       <= ST_INIT;
          r_mem_reset_L <= 1'b1;
        end
        ST_INIT: begin
          if (init) begin
            r_alto <= umbral_alto;
            r_bajo <= umbral_bajo;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_underflow) begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end else if (init) begin
            r_state <= ST_INIT;
          end else if (w_wr) begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_overflow) begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end else if (w_count_next == '0) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ERROR: r_state <= ST_ERROR;
        default: begin
          r_state <= ST_ERROR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign wr_en        = w_wr;
  assign rd_en        = w_rd;
  assign mem_reset_L  = r_mem_reset_L;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= r_alto);
  assign almost_empty = (r_count <= r_bajo);
  assign error        = r_error;
  assign state        = r_state;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: reference model plus a pointer scoreboard.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, init, push, pop;
  logic [3:0] umbral_alto, umbral_bajo;
  logic       wr_en, rd_en, mem_reset_L;
  logic [2:0] ptr_write, ptr_read;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, error;
  logic [2:0] state;

  fifo_ctrl #(.MAIN_QUEUE_SIZE(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .push         (push),
    .pop          (pop),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ptr_write    (ptr_write),
    .ptr_read     (ptr_read),
    .mem_reset_L  (mem_reset_L),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error),
    .state        (state)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     m_count, m_wp, m_rp, m_alto, m_bajo;
  state_t m_state;
  logic   m_err;
  int     sb[$];

  // One clock of push/pop: enables checked mid-cycle, read pointer checked
  // against the scoreboard of write slots, full register image after the edge.
  task automatic drive_cycle(input logic p, input logic q);
    logic ok, ew, er, ov, un;
    int exp_slot;
    logic [17:0] exp_v, got_v;
    push = p;
    pop  = q;
    ok = (m_state == ST_ACTIVE) || (m_state == ST_IDLE && init == 1'b0);
    ew = ok && p && (m_count != DEPTH || q);
    er = ok && q && (m_count != 0);
    ov = ok && p && (m_count == DEPTH) && !q;
    un = ok && q && (m_count == 0);
    @(negedge clk);
    n_checks++;
    if ({wr_en, rd_en} !== {ew, er}) begin
      n_fail++;
      $display("FAIL enables: wr_en/rd_en got %b%b expected %b%b", wr_en, rd_en, ew, er);
    end
    if (ew) sb.push_back(m_wp);
    if (er) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: read at ptr %0d with no outstanding entry", ptr_read);
      end else begin
        exp_slot = sb.pop_front();
        if (ptr_read !== 3'(exp_slot)) begin
          n_fail++;
          $display("FAIL read_order: ptr_read got %0d expected %0d", ptr_read, exp_slot);
        end
      end
    end
    @(posedge clk);
    #1;
    m_count = m_count + int'(ew) - int'(er);
    m_wp = (m_wp + int'(ew)) % DEPTH;
    m_rp = (m_rp + int'(er)) % DEPTH;
    case (m_state)
      ST_IDLE:   if (un) m_state = ST_ERROR; else if (ew) m_state = ST_ACTIVE;
      ST_ACTIVE: if (ov) m_state = ST_ERROR; else if (m_count == 0) m_state = ST_IDLE;
      default:   m_state = m_state;
    endcase
    if (ov || un) m_err = 1'b1;
    exp_v = {m_state, 4'(m_count), 3'(m_wp), 3'(m_rp), m_err,
             m_count == DEPTH, m_count == 0, m_count >= m_alto, m_count <= m_bajo};
    got_v = {state, count, ptr_write, ptr_read, error, full, empty, almost_full, almost_empty};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL regs: {state,count,wp,rp,err,full,empty,af,ae} got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_reset(input int alto, input int bajo);
    reset = 1'b1; init = 1'b0; push = 1'b1; pop = 1'b1;
    umbral_alto = 4'(alto); umbral_bajo = 4'(bajo);
    #1;
    n_checks++;
    if ({state, mem_reset_L, wr_en, rd_en, count, full, empty, almost_full, almost_empty, error}
        !== {3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d mrl=%b wr=%b rd=%b cnt=%0d f=%b e=%b af=%b ae=%b err=%b",
               state, mem_reset_L, wr_en, rd_en, count, full, empty, almost_full, almost_empty, error);
    end
    @(negedge clk);
    reset = 1'b0; push = 1'b0; pop = 1'b0; init = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({state, mem_reset_L} !== {3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL enter_init: state/mem_reset_L got %0d/%b expected 1/1", state, mem_reset_L);
    end
    @(posedge clk); #1;
    init = 1'b0;
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL hold_init: state got %0d expected 1", state);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({state, mem_reset_L, empty, almost_empty, almost_full} !== {3'd2, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL enter_idle: state=%0d mrl=%b e=%b ae=%b af=%b expected 2 1 1 1 0",
               state, mem_reset_L, empty, almost_empty, almost_full);
    end
    sb.delete();
    m_count = 0; m_wp = 0; m_rp = 0; m_err = 1'b0; m_state = ST_IDLE;
    m_alto = alto; m_bajo = bajo;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0);
    n_checks++;
    if ({full, ptr_write, count} !== {1'b1, 3'd0, 4'd8}) begin
      n_fail++;
      $display("FAIL fill: full/ptr_write/count got %b/%0d/%0d expected 1/0/8", full, ptr_write, count);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b1);
  endtask

  task automatic test_overflow();
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1);
  endtask

  task automatic test_underflow();
    test_reset(6, 2);
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    test_reset(6, 2);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0);
    push = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({count, empty, state, error, mem_reset_L} !== {4'd0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: cnt=%0d e=%b state=%0d err=%b mrl=%b expected 0 1 0 0 0",
               count, empty, state, error, mem_reset_L);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset(6, 2);
    test_fill();
    test_full_push_pop();
    test_overflow();
    test_underflow();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
